// File: rtl/pps_pulse_monitor.sv
// pps_pulse_monitor
//
// Receive-side monitor for a pulse train referenced to a PPS input. For each pulse it
// measures the phase of its rising edge from the most recent PPS edge (us), its high
// time (us), and the number of PPS edges since the previous pulse rise. Results are
// published together and held for register readback with a valid/ack handshake.
//
// Ports:
//   i_clk_10      10 MHz clock, the only clock
//   i_rst_n       asynchronous active-low reset
//   i_pps_raw     asynchronous PPS reference
//   i_pulse       asynchronous pulse under measurement
//   i_enable      any nonzero value enables measurement
//   i_ack         one-cycle strobe clearing o_valid, o_timeout and o_overrun
//   o_phase_us    us from last PPS rise to pulse rise
//   o_width_us    pulse high time in us
//   o_period_pps  PPS edges between the previous and this pulse rise
//   o_valid       a new result set is held
//   o_timeout     sticky, no pulse rise within TIMEOUT_PPS PPS edges
//   o_overrun     sticky, a publish occurred while o_valid was still set
//   o_busy        FSM is not idle
//
// Build options:
//   PPS_MON_OVERRUN_EN  when defined, o_overrun is implemented; otherwise tied 0.
//   DATA_WIDTH          register width, normally provided by address_map.vh; a default
//                       is supplied here when the macro is not already defined.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module pps_pulse_monitor #(
    parameter int unsigned CLKS_PER_US = 10,
    parameter int unsigned TIMEOUT_PPS = 16
) (
    input  logic                     i_clk_10,
    input  logic                     i_rst_n,
    input  logic                     i_pps_raw,
    input  logic                     i_pulse,
    input  logic [`DATA_WIDTH-1:0]   i_enable,
    input  logic                     i_ack,
    output logic [`DATA_WIDTH*3-1:0] o_phase_us,
    output logic [`DATA_WIDTH-1:0]   o_width_us,
    output logic [`DATA_WIDTH-1:0]   o_period_pps,
    output logic                     o_valid,
    output logic                     o_timeout,
    output logic                     o_overrun,
    output logic                     o_busy
);

    localparam int unsigned DW = `DATA_WIDTH;
    localparam int unsigned PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_US - 1);
    // A prescaler restarted by an edge counts the detect cycle itself, so that the
    // count seen k cycles later is floor(k / CLKS_PER_US).
    localparam logic [PW-1:0] PRESC_START = (CLKS_PER_US > 1) ? PW'(1) : {PW{1'b0}};
    localparam logic          US_START    = (CLKS_PER_US == 1);

    typedef enum logic [2:0] {StIdle, StSync, StArmed, StHigh, StLow} state_t;

    state_t state;

    // Input conditioning: two sync flops plus one history flop per input
    logic [2:0] pps_sr;
    logic [2:0] pulse_sr;
    logic       pps_rise;
    logic       pulse_rise;
    logic       pulse_fall;

    always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pps_sr   <= 3'b000;
            pulse_sr <= 3'b000;
        end else begin
            pps_sr   <= {pps_sr[1:0], i_pps_raw};
            pulse_sr <= {pulse_sr[1:0], i_pulse};
        end
    end

    assign pps_rise   =  pps_sr[1]   & ~pps_sr[2];
    assign pulse_rise =  pulse_sr[1] & ~pulse_sr[2];
    assign pulse_fall = ~pulse_sr[1] &  pulse_sr[2];

    // Time base: microseconds since the last PPS rise
    logic [PW-1:0]     us_presc;
    logic [3*DW-1:0]   us_since_pps;

    always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            us_presc     <= '0;
            us_since_pps <= '0;
        end else if (pps_rise) begin
            us_presc     <= PRESC_START;
            us_since_pps <= {{(3*DW-1){1'b0}}, US_START};
        end else if (us_presc == PRESC_LAST) begin
            us_presc <= '0;
            if (us_since_pps != '1) begin
                us_since_pps <= us_since_pps + 1'b1;
            end
        end else begin
            us_presc <= us_presc + 1'b1;
        end
    end

    // Width counter: its own prescaler, restarted on every pulse rise
    logic [PW-1:0] w_presc;
    logic [DW-1:0] w_cnt;

    always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_presc <= '0;
            w_cnt   <= '0;
        end else if (pulse_rise) begin
            w_presc <= PRESC_START;
            w_cnt   <= {{(DW-1){1'b0}}, US_START};
        end else if (w_presc == PRESC_LAST) begin
            w_presc <= '0;
            if (w_cnt != '1) begin
                w_cnt <= w_cnt + 1'b1;
            end
        end else begin
            w_presc <= w_presc + 1'b1;
        end
    end

    // PPS counting and derived conditions
    logic [DW-1:0]   pps_cnt;
    logic [DW-1:0]   pps_inc;
    logic [3*DW-1:0] phase_cap;
    logic            enabled;
    logic            in_measure;
    logic            timeout_hit;
    logic            timeout_set;
    logic            publish;
    logic [3*DW-1:0] phase_lat;
    logic [DW-1:0]   period_lat;
    logic            period_known;

    always_comb begin
        pps_inc = pps_cnt;
        if (pps_rise && (pps_cnt != '1)) begin
            pps_inc = pps_cnt + 1'b1;
        end
    end

    assign enabled    = |i_enable;
    assign in_measure = (state == StArmed) || (state == StHigh) || (state == StLow);
    // A coincident PPS edge is counted before the phase restarts at zero
    assign phase_cap  = pps_rise ? '0 : us_since_pps;

    // Fires once, on the PPS edge that takes the count past the limit
    assign timeout_hit = pps_rise && !pulse_rise &&
                         (pps_inc > DW'(TIMEOUT_PPS)) && (pps_cnt <= DW'(TIMEOUT_PPS));
    assign timeout_set = enabled && in_measure && timeout_hit;
    assign publish     = enabled && (state == StHigh) && pulse_fall && !timeout_hit &&
                         period_known;

    always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= StIdle;
            pps_cnt      <= '0;
            phase_lat    <= '0;
            period_lat   <= '0;
            period_known <= 1'b0;
            o_phase_us   <= '0;
            o_width_us   <= '0;
            o_period_pps <= '0;
            o_valid      <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            if ((state == StIdle) || !enabled || pulse_rise) begin
                pps_cnt <= '0;
            end else begin
                pps_cnt <= pps_inc;
            end

            if (!enabled) begin
                state        <= StIdle;
                period_known <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        period_known <= 1'b0;
                        state        <= StSync;
                    end
                    StSync: begin
                        if (pps_rise) begin
                            state <= StArmed;
                        end
                    end
                    StArmed: begin
                        if (timeout_hit) begin
                            period_known <= 1'b0;
                        end else if (pulse_rise) begin
                            phase_lat <= phase_cap;
                            state     <= StHigh;
                        end
                    end
                    StHigh: begin
                        if (timeout_hit) begin
                            period_known <= 1'b0;
                            state        <= StArmed;
                        end else if (pulse_fall) begin
                            state <= StLow;
                        end
                    end
                    StLow: begin
                        if (timeout_hit) begin
                            period_known <= 1'b0;
                            state        <= StArmed;
                        end else if (pulse_rise) begin
                            period_lat   <= pps_inc;
                            phase_lat    <= phase_cap;
                            period_known <= 1'b1;
                            state        <= StHigh;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end

            if (publish) begin
                o_phase_us   <= phase_lat;
                o_width_us   <= w_cnt;
                o_period_pps <= period_lat;
            end

            // Set beats ack when both land in the same cycle
            if (publish) begin
                o_valid <= 1'b1;
            end else if (i_ack) begin
                o_valid <= 1'b0;
            end

            if (timeout_set) begin
                o_timeout <= 1'b1;
            end else if (i_ack) begin
                o_timeout <= 1'b0;
            end
        end
    end

`ifdef PPS_MON_OVERRUN_EN
    always_ff @(posedge i_clk_10 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overrun <= 1'b0;
        end else if (publish && o_valid && !i_ack) begin
            o_overrun <= 1'b1;
        end else if (i_ack) begin
            o_overrun <= 1'b0;
        end
    end
`else
    assign o_overrun = 1'b0;
`endif

    assign o_busy = (state != StIdle);

endmodule

// File: tb/tb_pps_pulse_monitor.sv
// Directed bench for pps_pulse_monitor. PPS period is 2000 clocks; all pulse timing is
// expressed relative to a bench time index t so expected values follow from the pattern.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_pps_pulse_monitor;

    localparam int PPS_P = 2000;

    logic                     clk;
    logic                     rst_n;
    logic                     pps_raw;
    logic                     pulse;
    logic [`DATA_WIDTH-1:0]   enable;
    logic                     ack;
    logic [`DATA_WIDTH*3-1:0] phase_us;
    logic [`DATA_WIDTH-1:0]   width_us;
    logic [`DATA_WIDTH-1:0]   period_pps;
    logic                     valid;
    logic                     timeout;
    logic                     overrun;
    logic                     busy;

    int vecs = 0;
    int errs = 0;

`ifdef PPS_MON_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    pps_pulse_monitor #(
        .CLKS_PER_US (10),
        .TIMEOUT_PPS (16)
    ) dut (
        .i_clk_10     (clk),
        .i_rst_n      (rst_n),
        .i_pps_raw    (pps_raw),
        .i_pulse      (pulse),
        .i_enable     (enable),
        .i_ack        (ack),
        .o_phase_us   (phase_us),
        .o_width_us   (width_us),
        .o_period_pps (period_pps),
        .o_valid      (valid),
        .o_timeout    (timeout),
        .o_overrun    (overrun),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clock per t. PPS is high for 20 clocks each period; the pulse is high for w
    // clocks starting at off, repeating every stride clocks (stride 0: no pulse).
    task automatic drive(input int t0, input int n, input int off, input int stride,
                         input int w);
        for (int t = t0; t < t0 + n; t++) begin
            pps_raw = ((t % PPS_P) < 20);
            pulse   = (stride > 0) && (t >= off) && (((t - off) % stride) < w);
            step();
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic restart();
        pps_raw = 1'b0;
        pulse   = 1'b0;
        enable  = '0;
        repeat (4) step();
        enable = 'd1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        vecs++; if (phase_us !== '0) begin errs++;
            $display("FAIL reset_phase: got %0d expected 0", phase_us); end
        vecs++; if (width_us !== '0) begin errs++;
            $display("FAIL reset_width: got %0d expected 0", width_us); end
        vecs++; if (period_pps !== '0) begin errs++;
            $display("FAIL reset_period: got %0d expected 0", period_pps); end
        vecs++; if (valid !== 1'b0) begin errs++;
            $display("FAIL reset_valid: got %0d expected 0", valid); end
        vecs++; if (timeout !== 1'b0) begin errs++;
            $display("FAIL reset_timeout: got %0d expected 0", timeout); end
        vecs++; if (overrun !== 1'b0) begin errs++;
            $display("FAIL reset_overrun: got %0d expected 0", overrun); end
        vecs++; if (busy !== 1'b0) begin errs++;
            $display("FAIL reset_busy: got %0d expected 0", busy); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_nominal();
        restart();
        // PPS at 0 and 2000; first pulse 500..799 gives no publish
        drive(0, 4000, 500, 4000, 300);
        vecs++; if (valid !== 1'b0) begin errs++;
            $display("FAIL nominal_no_first_publish: got %0d expected 0", valid); end
        vecs++; if (busy !== 1'b1) begin errs++;
            $display("FAIL nominal_busy: got %0d expected 1", busy); end
        // PPS at 4000, second pulse 4500..4799
        drive(4000, 2000, 500, 4000, 300);
        vecs++; if (valid !== 1'b1) begin errs++;
            $display("FAIL nominal_valid: got %0d expected 1", valid); end
        vecs++; if (phase_us !== 'd50) begin errs++;
            $display("FAIL nominal_phase: got %0d expected 50", phase_us); end
        vecs++; if (width_us !== 'd30) begin errs++;
            $display("FAIL nominal_width: got %0d expected 30", width_us); end
        vecs++; if (period_pps !== 'd2) begin errs++;
            $display("FAIL nominal_period: got %0d expected 2", period_pps); end
        do_ack();
        vecs++; if (valid !== 1'b0) begin errs++;
            $display("FAIL nominal_ack_valid: got %0d expected 0", valid); end
    endtask

    task automatic test_coincident();
        restart();
        // PPS 0 arms, pulse at 2000 is the first rise, pulse at 4000 publishes at ~4100
        drive(0, 6000, 0, 2000, 100);
        vecs++; if (valid !== 1'b1) begin errs++;
            $display("FAIL coinc_valid: got %0d expected 1", valid); end
        vecs++; if (phase_us !== 'd0) begin errs++;
            $display("FAIL coinc_phase: got %0d expected 0", phase_us); end
        vecs++; if (period_pps !== 'd1) begin errs++;
            $display("FAIL coinc_period: got %0d expected 1", period_pps); end
        vecs++; if (width_us !== 'd10) begin errs++;
            $display("FAIL coinc_width: got %0d expected 10", width_us); end
        do_ack();
    endtask

    task automatic test_rounding();
        int widths [3] = '{9, 10, 19};
        int expw   [3] = '{0, 1, 1};
        for (int i = 0; i < 3; i++) begin
            restart();
            drive(0, 4000, 500, 2000, widths[i]);
            vecs++; if (valid !== 1'b1) begin errs++;
                $display("FAIL round_valid_%0d: got %0d expected 1", widths[i], valid); end
            vecs++; if (width_us !== expw[i][`DATA_WIDTH-1:0]) begin errs++;
                $display("FAIL round_width_%0d: got %0d expected %0d", widths[i], width_us,
                         expw[i]); end
            do_ack();
        end
    endtask

    task automatic test_timeout();
        restart();
        // Publish from rise at 2500 (period 1), then pulses stop
        drive(0, 4000, 500, 2000, 300);
        vecs++; if (valid !== 1'b1) begin errs++;
            $display("FAIL to_pre_valid: got %0d expected 1", valid); end
        do_ack();
        // PPS edges 4000..34000 are the 1st..16th after the last rise
        drive(4000, 32000, 0, 0, 0);
        vecs++; if (timeout !== 1'b0) begin errs++;
            $display("FAIL to_16th_edge: got %0d expected 0", timeout); end
        drive(36000, 100, 0, 0, 0);
        vecs++; if (timeout !== 1'b1) begin errs++;
            $display("FAIL to_17th_edge: got %0d expected 1", timeout); end
        do_ack();
        vecs++; if (timeout !== 1'b0) begin errs++;
            $display("FAIL to_ack_clear: got %0d expected 0", timeout); end
        // One rise after timeout must not publish
        drive(36101, 3899, 38500, 2000, 300);
        vecs++; if (valid !== 1'b0) begin errs++;
            $display("FAIL to_one_rise_no_publish: got %0d expected 0", valid); end
        vecs++; if (timeout !== 1'b0) begin errs++;
            $display("FAIL to_no_refire: got %0d expected 0", timeout); end
        drive(40000, 2000, 38500, 2000, 300);
        vecs++; if (valid !== 1'b1) begin errs++;
            $display("FAIL to_second_rise_publish: got %0d expected 1", valid); end
        vecs++; if (period_pps !== 'd1) begin errs++;
            $display("FAIL to_period: got %0d expected 1", period_pps); end
        vecs++; if (phase_us !== 'd50) begin errs++;
            $display("FAIL to_phase: got %0d expected 50", phase_us); end
        do_ack();
    endtask

    task automatic test_disable_reset();
        restart();
        // Second rise at 2500 puts the FSM in HIGH with a known period
        drive(0, 2650, 500, 2000, 300);
        vecs++; if (busy !== 1'b1) begin errs++;
            $display("FAIL dis_busy_before: got %0d expected 1", busy); end
        enable = '0;
        drive(2650, 1, 500, 2000, 300);
        vecs++; if (busy !== 1'b0) begin errs++;
            $display("FAIL dis_busy_next: got %0d expected 0", busy); end
        drive(2651, 1349, 500, 2000, 300);
        vecs++; if (valid !== 1'b0) begin errs++;
            $display("FAIL dis_no_publish: got %0d expected 0", valid); end
        vecs++; if (phase_us !== 'd50) begin errs++;
            $display("FAIL dis_phase_hold: got %0d expected 50", phase_us); end
        vecs++; if (width_us !== 'd30) begin errs++;
            $display("FAIL dis_width_hold: got %0d expected 30", width_us); end
        vecs++; if (period_pps !== 'd1) begin errs++;
            $display("FAIL dis_period_hold: got %0d expected 1", period_pps); end
        // Asynchronous reset, checked before any further clock edge
        #2;
        rst_n = 1'b0;
        #1;
        vecs++; if (phase_us !== '0 || width_us !== '0 || period_pps !== '0) begin errs++;
            $display("FAIL async_rst_data: got %0d/%0d/%0d expected 0/0/0", phase_us,
                     width_us, period_pps); end
        vecs++; if (valid !== 1'b0 || timeout !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0)
            begin errs++;
            $display("FAIL async_rst_flags: got %0d%0d%0d%0d expected 0000", valid, timeout,
                     overrun, busy); end
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_overrun();
        restart();
        // Publishes at ~2800 and ~4800 with no ack between them
        drive(0, 6000, 500, 2000, 300);
        vecs++; if (valid !== 1'b1) begin errs++;
            $display("FAIL ovr_valid: got %0d expected 1", valid); end
        vecs++; if (overrun !== EXP_OVR) begin errs++;
            $display("FAIL ovr_flag: got %0d expected %0d", overrun, EXP_OVR); end
        do_ack();
        vecs++; if (overrun !== 1'b0) begin errs++;
            $display("FAIL ovr_ack_clear: got %0d expected 0", overrun); end
        vecs++; if (valid !== 1'b0) begin errs++;
            $display("FAIL ovr_ack_valid: got %0d expected 0", valid); end
    endtask

    initial begin
        rst_n   = 1'b0;
        pps_raw = 1'b0;
        pulse   = 1'b0;
        enable  = '0;
        ack     = 1'b0;
        test_reset();
        test_nominal();
        test_coincident();
        test_rounding();
        test_timeout();
        test_disable_reset();
        test_overrun();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
